// File: rtl/demux_1xn_reg_if.sv
// Beat-stream bundle between one source and NUM_OUT sinks of demux_1xn_reg.
interface demux_1xn_reg_if #(
    parameter int width   = 31,
    parameter int NUM_OUT = 4
);
    localparam int SEL_W = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;

    logic                         enable;
    logic [SEL_W-1:0]             select;
    logic [width:0]               in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic [NUM_OUT*(width+1)-1:0] out_data;
    logic [NUM_OUT-1:0]           out_valid;
    logic [NUM_OUT-1:0]           out_last;
    logic [NUM_OUT-1:0]           out_ready;
    logic                         busy;
    logic                         drop_err;

    modport master (
        output enable, select, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, drop_err
    );

    modport slave (
        input  enable, select, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, drop_err
    );
endinterface

// File: rtl/demux_1xn_reg.sv
// Registered 1-to-NUM_OUT beat demultiplexer: route locked per burst,
// one output register, out-of-range routes consumed and flagged.
module demux_1xn_reg #(
    parameter int width   = 31,
    parameter int NUM_OUT = 4
) (
    input logic            ACLK,
    input logic            ARESET,
    demux_1xn_reg_if.slave bus
);
    localparam int SEL_W = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;
    localparam int DW    = width + 1;
    localparam int NPAD  = 1 << SEL_W;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [SEL_W-1:0] route_lock;
    logic             vld_p1;
    logic             last_p1;
    logic [SEL_W-1:0] tgt_p1;
    logic [width:0]   data_p1;
    logic             drop_p1;

    logic [SEL_W-1:0] route;
    logic             route_oor;
    logic             hold_ready;
    logic             accept;
    logic             store;
    logic             drain;
    logic [NPAD-1:0]  ready_pad;

    logic [NUM_OUT*DW-1:0] out_data_c;
    logic [NUM_OUT-1:0]    out_valid_c;
    logic [NUM_OUT-1:0]    out_last_c;

    function automatic logic out_of_range(input logic [SEL_W-1:0] ch);
        return {1'b0, ch} >= (SEL_W+1)'(NUM_OUT);
    endfunction

    // Padding lets tgt_p1 index the ready vector without a range check.
    assign ready_pad  = NPAD'(bus.out_ready);
    assign route      = (state == LOCKED) ? route_lock : bus.select;
    assign route_oor  = out_of_range(route);
    assign drain      = vld_p1 && ready_pad[tgt_p1];
    assign hold_ready = !vld_p1 || ready_pad[tgt_p1];

    assign bus.in_ready = !ARESET && bus.enable && (route_oor || hold_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign store        = accept && !route_oor;

    // Stage p0 -> p1: routing control and output register occupancy
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            route_lock <= '0;
            vld_p1     <= 1'b0;
            tgt_p1     <= '0;
            drop_p1    <= 1'b0;
        end else begin
            drop_p1 <= accept && route_oor;
            if (store) begin
                vld_p1 <= 1'b1;
                tgt_p1 <= route;
            end else if (drain) begin
                vld_p1 <= 1'b0;
            end
            if (accept) begin
                if (state == IDLE) route_lock <= bus.select;
                state <= bus.in_last ? IDLE : LOCKED;
            end
        end
    end

    // Payload is qualified by vld_p1 everywhere, so it carries no reset.
    always_ff @(posedge ACLK) begin
        if (store) begin
            data_p1 <= bus.in_data;
            last_p1 <= bus.in_last;
        end
    end

    always_comb begin
        out_valid_c = '0;
        out_last_c  = '0;
        out_data_c  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (vld_p1 && (tgt_p1 == SEL_W'(k))) begin
                out_valid_c[k]         = 1'b1;
                out_last_c[k]          = last_p1;
                out_data_c[k*DW +: DW] = data_p1;
            end
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_data  = out_data_c;
    assign bus.busy      = (state == LOCKED) || vld_p1;
    assign bus.drop_err  = drop_p1;
endmodule
